// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO port: direction/output registers, synchronized inputs and
// optional edge interrupts (enabled with macro GPIO_IRQ_EN).
`timescale 1ns/1ps

module gpio_port_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        addr,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       wData,
    output logic [31:0]       rData,
    inout  wire  [WIDTH-1:0]  gpioPorts,
    output logic              irq
);

    localparam logic [2:0] SEL_DIR  = 3'd0;
    localparam logic [2:0] SEL_OUT  = 3'd1;
    localparam logic [2:0] SEL_IN   = 3'd2;
`ifdef GPIO_IRQ_EN
    localparam logic [2:0] SEL_IEN  = 3'd3;
    localparam logic [2:0] SEL_STS  = 3'd4;
    localparam logic [2:0] SEL_EDGE = 3'd5;
`endif

    logic [2:0]       sel_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_c;
    logic [31:0]      rd_data_c;
    logic             unused_bits;

    assign sel_c       = addr[4:2];
    assign wdata_c     = wData[WIDTH-1:0];
    assign in_c        = sync_q[SYNC_STAGES-1];
    assign unused_bits = ^{wData, addr[1:0]};

    // Tri-state pin drivers straight from the registers
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpioPorts[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q <= '0;
            out_q <= '0;
        end else if (we) begin
            if (sel_c == SEL_DIR) dir_q <= wdata_c;
            if (sel_c == SEL_OUT) out_q <= wdata_c;
        end
    end

    // Input synchronizer chain; the last stage is the IN register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpioPorts;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_IRQ_EN
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [WIDTH-1:0]  irq_en_q;
    logic [WIDTH-1:0]  status_q;
    logic [WIDTH-1:0]  edge_sel_q;
    logic [WIDTH-1:0]  in_prev_q;
    logic [WARM_W-1:0] warm_cnt_q;
    logic              armed_c;
    logic [WIDTH-1:0]  edge_hit_c;
    logic [WIDTH-1:0]  clr_c;

    // Edges are ignored until the synchronizer and inPrev hold real pin data
    assign armed_c    = (warm_cnt_q == WARM_W'(WARM_CYCLES));
    assign edge_hit_c = armed_c ? ((edge_sel_q & in_c & ~in_prev_q) |
                                   (~edge_sel_q & ~in_c & in_prev_q)) : '0;
    assign clr_c      = (we && sel_c == SEL_STS) ? wdata_c : '0;
    assign irq        = |(status_q & irq_en_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            status_q   <= '0;
            in_prev_q  <= '0;
            warm_cnt_q <= '0;
        end else begin
            if (we && sel_c == SEL_IEN)  irq_en_q   <= wdata_c;
            if (we && sel_c == SEL_EDGE) edge_sel_q <= wdata_c;
            // A new edge overrides a simultaneous write-1-to-clear
            status_q  <= (status_q & ~clr_c) | edge_hit_c;
            in_prev_q <= in_c;
            if (!armed_c) warm_cnt_q <= warm_cnt_q + WARM_W'(1);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data_c = '0;
        case (sel_c)
            SEL_DIR:  rd_data_c = 32'(dir_q);
            SEL_OUT:  rd_data_c = 32'(out_q);
            SEL_IN:   rd_data_c = 32'(in_c);
`ifdef GPIO_IRQ_EN
            SEL_IEN:  rd_data_c = 32'(irq_en_q);
            SEL_STS:  rd_data_c = 32'(status_q);
            SEL_EDGE: rd_data_c = 32'(edge_sel_q);
`endif
            default:  rd_data_c = '0;
        endcase
    end

    // Read data reflects register state before any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            rData <= '0;
        end else if (re) begin
            rData <= rd_data_c;
        end
    end

endmodule
